pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum consecutive data-memory wait cycles before an error is raised.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 hz_stall  input  1  load-use stall request from the hazard detection unit.
REQ-006 branch_taken  input  1  branch or jump resolved taken in EX; redirect required.
REQ-007 dmem_req  input  1  MEM-stage instruction is accessing data memory this cycle.
REQ-008 dmem_ready  input  1  data memory completes the access this cycle.
REQ-009 pc_write  output  1  PC register load enable.
REQ-010 ifid_write  output  1  IF/ID register load enable.
REQ-011 ifid_flush  output  1  IF/ID is cleared to a NOP on this edge.
REQ-012 idex_bubble  output  1  ID/EX control fields are zeroed (bubble) on this edge.
REQ-013 pipe_hold  output  1  ID/EX, EX/MEM and MEM/WB hold their contents.
REQ-014 mem_err  output  1  sticky data-memory timeout error.
REQ-015 stall_cnt  output  CNT_W  cycles in which pc_write was 0, saturating.
REQ-016 flush_cnt  output  CNT_W  cycles in which ifid_flush was 1, saturating.

Function
REQ-017 The FSM SHALL have three registered states: RUN, MEM_WAIT and ERROR.
REQ-018 Control outputs SHALL be combinational from the current state and current inputs; the state, the wait counter and the performance counters SHALL be registered.
REQ-019 Priority when evaluating in RUN SHALL be: memory freeze > branch flush > load-use stall > normal.
REQ-020 RUN, freeze (dmem_req=1, dmem_ready=0): pc_write=0, ifid_write=0, pipe_hold=1, ifid_flush=0, idex_bubble=0; next state MEM_WAIT; wait_cnt<=1.
REQ-021 RUN, flush (branch_taken=1, no freeze): pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, pipe_hold=0; hz_stall is ignored in this cycle.
REQ-022 RUN, stall (hz_stall=1, no freeze, no branch): pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, pipe_hold=0.
REQ-023 RUN, normal: pc_write=1, ifid_write=1, all other control outputs 0.
REQ-024 MEM_WAIT with dmem_ready=0: full freeze as in REQ-020; wait_cnt increments.
REQ-025 MEM_WAIT with dmem_ready=1: freeze released in that same cycle; outputs follow REQ-021 to REQ-023 from the current branch_taken and hz_stall; next state RUN; wait_cnt<=0.
REQ-026 A branch_taken asserted during a freeze SHALL NOT produce a flush until the release cycle; EX is held, so the input remains valid.
REQ-027 When wait_cnt reaches MEM_TIMEOUT while in MEM_WAIT with dmem_ready=0, the next state SHALL be ERROR.
REQ-028 ERROR: mem_err=1, pc_write=0, ifid_write=0, pipe_hold=1, ifid_flush=0, idex_bubble=0; all inputs are ignored; only reset exits this state.
REQ-029 wait_cnt SHALL be wide enough to hold MEM_TIMEOUT and SHALL never wrap.
REQ-030 stall_cnt SHALL increment by 1 in every cycle with pc_write=0, including ERROR cycles, and SHALL hold at all-ones.
REQ-031 flush_cnt SHALL increment by 1 in every cycle with ifid_flush=1 and SHALL hold at all-ones.
REQ-032 dmem_ready=1 with dmem_req=0 in RUN SHALL have no effect.

Reset
REQ-033 On reset=1 at a rising edge: state<=RUN, wait_cnt<=0, stall_cnt<=0, flush_cnt<=0, mem_err<=0.
REQ-034 Reset SHALL take effect from any state, including mid-MEM_WAIT and ERROR.
REQ-035 While reset=1, outputs SHALL reflect state RUN with no counter updates; the first cycle after reset with idle inputs gives pc_write=1, ifid_write=1, all other outputs 0.

Verification
REQ-036 Load-use: hz_stall=1 for 1 cycle in RUN -> pc_write=0, ifid_write=0, idex_bubble=1 for 1 cycle; stall_cnt=1.
REQ-037 Branch plus stall: branch_taken=1 and hz_stall=1 together -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1; stall_cnt unchanged.
REQ-038 Memory wait: dmem_req=1 with dmem_ready low for 3 cycles then high -> pipe_hold=1 for 3 cycles, released on cycle 4; stall_cnt=3; state back to RUN.
REQ-039 Branch during wait: branch_taken=1 throughout a 2-cycle wait -> no flush for 2 cycles; ifid_flush=1 in the release cycle only.
REQ-040 Timeout: MEM_TIMEOUT=4, dmem_ready stuck low -> ERROR after 4 wait cycles; mem_err=1 held; reset=1 for 1 cycle -> RUN, all counters 0, mem_err=0.
REQ-041 Saturation: CNT_W=4 with 20 consecutive hz_stall cycles -> stall_cnt=15 and held.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - pipeline hazard/memory handshake bundle for the stall controller
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hz_stall;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_hold;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // pipeline side: raises hazard/memory status, consumes the enables
  modport master (
    output hz_stall, branch_taken, dmem_req, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
    input  mem_err, stall_cnt, flush_cnt
  );

  // controller side
  modport slave (
    input  hz_stall, branch_taken, dmem_req, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
    output mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush/freeze controller with memory timeout
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_stall_ctrl_if.slave   bus
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state;
  state_t            eff_state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_bubble;
  logic pipe_hold;
  logic mem_err;

  // Decode control enables and next state; reset makes the block look like RUN
  // so the pipeline keeps flowing while reset is held.
  always_comb begin
    eff_state   = reset ? RUN : state;
    next_state  = eff_state;
    wait_nxt    = wait_cnt;
    mem_err     = 1'b0;
    pipe_hold   = 1'b0;

    // Flow decision (branch beats load-use), overridden below by a freeze.
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (bus.branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (bus.hz_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end

    case (eff_state)
      RUN: begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          ifid_flush  = 1'b0;
          idex_bubble = 1'b0;
          pipe_hold   = 1'b1;
          next_state  = MEM_WAIT;
          wait_nxt    = WAIT_ONE;
        end
      end
      MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          ifid_flush  = 1'b0;
          idex_bubble = 1'b0;
          pipe_hold   = 1'b1;
          // Counter stops at the limit, so it can never wrap.
          if (wait_cnt >= TIMEOUT) begin
            next_state = ERROR;
          end else begin
            wait_nxt = wait_cnt + WAIT_ONE;
          end
        end else begin
          // Release cycle: the held branch/stall takes effect now.
          next_state = RUN;
          wait_nxt   = '0;
        end
      end
      ERROR: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b1;
        mem_err     = 1'b1;
      end
      default: begin
        next_state = RUN;
        wait_nxt   = '0;
      end
    endcase
  end

  // State, wait counter and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_nxt;
      if (!pc_write && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (ifid_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.pipe_hold   = pipe_hold;
  assign bus.mem_err     = mem_err;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed-vector bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 4;
  localparam int TO    = 4;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_err}
  localparam logic [5:0] NORM   = 6'b110000;
  localparam logic [5:0] FLUSH  = 6'b111100;
  localparam logic [5:0] STALL  = 6'b000100;
  localparam logic [5:0] FREEZE = 6'b000010;
  localparam logic [5:0] ERR    = 6'b000011;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [5:0] ctl;
  assign ctl = {bus.pc_write, bus.ifid_write, bus.ifid_flush,
                bus.idex_bubble, bus.pipe_hold, bus.mem_err};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, check control outputs mid-cycle, commit the edge.
  task automatic cyc(input logic hz, input logic br, input logic req, input logic rdy,
                     input logic [5:0] exp, input string tag);
    bus.hz_stall     = hz;
    bus.branch_taken = br;
    bus.dmem_req     = req;
    bus.dmem_ready   = rdy;
    @(negedge clk);
    check(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset            = 1'b1;
    bus.hz_stall     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.dmem_req     = 1'b0;
    bus.dmem_ready   = 1'b0;
    @(negedge clk);
    check({tag, "_rst_ctl"}, 32'(ctl), 32'(NORM));
    @(posedge clk);
    #1;
    reset = 1'b0;
    check({tag, "_rst_stall"}, 32'(bus.stall_cnt), 32'd0);
    check({tag, "_rst_flush"}, 32'(bus.flush_cnt), 32'd0);
  endtask

  initial begin
    clk              = 1'b0;
    reset            = 1'b1;
    total            = 0;
    bad              = 0;
    bus.hz_stall     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.dmem_req     = 1'b0;
    bus.dmem_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("init_stall", 32'(bus.stall_cnt), 32'd0);
    check("init_flush", 32'(bus.flush_cnt), 32'd0);
    cyc(0, 0, 0, 0, NORM, "init_idle");

    // load-use stall for one cycle
    do_reset("lu");
    cyc(1, 0, 0, 0, STALL, "lu_stall");
    check("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    cyc(0, 0, 0, 0, NORM, "lu_after");
    check("lu_flush_cnt", 32'(bus.flush_cnt), 32'd0);

    // branch beats load-use
    do_reset("bs");
    cyc(1, 1, 0, 0, FLUSH, "bs_flush");
    check("bs_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    check("bs_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // ready without a request, and a same-cycle completed access, do nothing
    do_reset("rdy");
    cyc(0, 0, 0, 1, NORM, "rdy_noreq");
    cyc(0, 0, 1, 1, NORM, "rdy_req");
    cyc(0, 0, 0, 0, NORM, "rdy_idle");
    check("rdy_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // three-cycle memory wait, freeze outranks load-use
    do_reset("mw");
    cyc(0, 0, 1, 0, FREEZE, "mw_c1");
    cyc(1, 0, 1, 0, FREEZE, "mw_c2");
    cyc(0, 0, 1, 0, FREEZE, "mw_c3");
    cyc(0, 0, 1, 1, NORM, "mw_release");
    check("mw_stall_cnt", 32'(bus.stall_cnt), 32'd3);
    cyc(0, 0, 0, 0, NORM, "mw_run");
    check("mw_flush_cnt", 32'(bus.flush_cnt), 32'd0);

    // branch held through a two-cycle wait flushes only on release
    do_reset("bw");
    cyc(0, 1, 1, 0, FREEZE, "bw_c1");
    cyc(0, 1, 1, 0, FREEZE, "bw_c2");
    cyc(0, 1, 1, 1, FLUSH, "bw_release");
    check("bw_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    check("bw_stall_cnt", 32'(bus.stall_cnt), 32'd2);
    cyc(0, 0, 0, 0, NORM, "bw_after");

    // load-use seen in the release cycle
    do_reset("hw");
    cyc(0, 0, 1, 0, FREEZE, "hw_c1");
    cyc(1, 0, 1, 1, STALL, "hw_release");
    check("hw_stall_cnt", 32'(bus.stall_cnt), 32'd2);

    // reset in the middle of a wait returns to RUN
    do_reset("rm");
    cyc(0, 0, 1, 0, FREEZE, "rm_c1");
    cyc(0, 0, 1, 0, FREEZE, "rm_c2");
    do_reset("rm2");
    cyc(0, 0, 0, 0, NORM, "rm_run");

    // timeout: wait_cnt hits 4 on the fifth frozen cycle, ERROR follows
    do_reset("to");
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 1, 0, FREEZE, $sformatf("to_frz%0d", i));
    end
    check("to_stall5", 32'(bus.stall_cnt), 32'd5);
    cyc(0, 0, 1, 0, ERR, "to_err1");
    cyc(0, 0, 0, 0, ERR, "to_err2");
    cyc(1, 1, 1, 1, ERR, "to_err3");
    check("to_stall8", 32'(bus.stall_cnt), 32'd8);
    check("to_flush", 32'(bus.flush_cnt), 32'd0);
    do_reset("to2");
    cyc(0, 0, 0, 0, NORM, "to_run");

    // saturation of both counters
    do_reset("sat");
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0, STALL, "sat_stall");
    end
    check("sat_stall15", 32'(bus.stall_cnt), 32'd15);
    cyc(1, 0, 0, 0, STALL, "sat_stall_more");
    check("sat_stall_hold", 32'(bus.stall_cnt), 32'd15);
    do_reset("satf");
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, 0, FLUSH, "sat_flush");
    end
    check("sat_flush15", 32'(bus.flush_cnt), 32'd15);
    check("sat_flush_stall", 32'(bus.stall_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
